// File: rtl/output_sram_write_arbiter.sv
// Round-robin arbiter between edge buffer banks and the output SRAM: grants one bank,
// captures its sos..eos feature-vector beat stream and turns each beat into a registered SRAM write.
module output_sram_write_arbiter #(
  parameter int NUM_BANKS  = 4,
  parameter int MAX_FV_NUM = 8,
  parameter int NODE_ID_W  = 6,
  parameter int WPN        = MAX_FV_NUM / 2,
  parameter int ADDR_W     = NODE_ID_W + $clog2(WPN)
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic [NUM_BANKS-1:0]          bank_req,
  output logic [NUM_BANKS-1:0]          bank_grant,
  input  logic [NUM_BANKS-1:0]          bank_valid,
  input  logic [NUM_BANKS-1:0]          bank_sos,
  input  logic [NUM_BANKS-1:0]          bank_eos,
  input  logic [NUM_BANKS*16-1:0]       bank_data,
  input  logic [NUM_BANKS*NODE_ID_W-1:0] bank_node_id,
  output logic                          sram_wen,
  output logic [ADDR_W-1:0]             sram_addr,
  output logic [15:0]                   sram_wdata,
  output logic                          busy,
  output logic                          stream_err
);

  localparam int BW = $clog2(WPN);
  localparam int IW = (NUM_BANKS > 1) ? $clog2(NUM_BANKS) : 1;

  localparam logic [1:0] IDLE   = 2'd0;
  localparam logic [1:0] GRANT  = 2'd1;
  localparam logic [1:0] STREAM = 2'd2;

  logic [1:0]           state;
  logic [IW-1:0]        winner;
  logic [IW-1:0]        rr_ptr;
  logic [IW-1:0]        next_winner;
  logic [IW-1:0]        rr_next;
  logic                 found;
  logic [NODE_ID_W-1:0] node_q;
  logic [BW-1:0]        beat_idx;

  logic                 w_valid;
  logic                 w_sos;
  logic                 w_eos;
  logic [15:0]          w_data;
  logic [NODE_ID_W-1:0] w_node;

  // First requester at or after rr_ptr, wrapping around the bank count
  always_comb begin
    next_winner = rr_ptr;
    found       = 1'b0;
    for (int i = 0; i < NUM_BANKS; i++) begin
      if (!found && bank_req[(int'(rr_ptr) + i) % NUM_BANKS]) begin
        found       = 1'b1;
        next_winner = IW'((int'(rr_ptr) + i) % NUM_BANKS);
      end
    end
  end

  assign rr_next = (int'(winner) == NUM_BANKS - 1) ? '0 : winner + IW'(1);

  assign w_valid = bank_valid[winner];
  assign w_sos   = bank_sos[winner];
  assign w_eos   = bank_eos[winner];
  assign w_data  = bank_data[int'(winner)*16 +: 16];
  assign w_node  = bank_node_id[int'(winner)*NODE_ID_W +: NODE_ID_W];

  always_comb begin
    bank_grant = '0;
    if (state == GRANT) bank_grant[winner] = 1'b1;
  end

  assign busy = (state != IDLE);

  // Beats from the winner become next-cycle SRAM writes; everything else is ignored
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state      <= IDLE;
      winner     <= '0;
      rr_ptr     <= '0;
      node_q     <= '0;
      beat_idx   <= '0;
      sram_wen   <= 1'b0;
      sram_addr  <= '0;
      sram_wdata <= '0;
      stream_err <= 1'b0;
    end else begin
      sram_wen <= 1'b0;
      case (state)
        IDLE: begin
          if (found) begin
            winner <= next_winner;
            state  <= GRANT;
          end
        end
        GRANT: begin
          if (w_valid && w_sos) begin
            node_q     <= w_node;
            sram_wen   <= 1'b1;
            sram_addr  <= {w_node, {BW{1'b0}}};
            sram_wdata <= w_data;
            if (w_eos) begin
              state    <= IDLE;
              rr_ptr   <= rr_next;
              beat_idx <= '0;
            end else begin
              state    <= STREAM;
              beat_idx <= BW'(1);
            end
          end
        end
        STREAM: begin
          if (w_valid) begin
            sram_wen   <= 1'b1;
            sram_addr  <= {node_q, beat_idx};
            sram_wdata <= w_data;
            if (w_sos) stream_err <= 1'b1;
            // A full node without eos is an overflow: keep the write, abandon the stream
            if (w_eos || beat_idx == BW'(WPN - 1)) begin
              state    <= IDLE;
              rr_ptr   <= rr_next;
              beat_idx <= '0;
              if (!w_eos) stream_err <= 1'b1;
            end else begin
              beat_idx <= beat_idx + BW'(1);
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_output_sram_write_arbiter.sv
// Self-checking bench: bank driver tasks stream beats while a monitor logs SRAM writes and grants;
// expected writes come from node*WPN+beat arithmetic recorded as each beat is offered.
module tb_output_sram_write_arbiter;
  localparam int NB  = 4;
  localparam int FV  = 8;
  localparam int WPN = FV / 2;
  localparam int NW  = 6;
  localparam int AW  = NW + $clog2(WPN);

  logic              clk = 1'b0;
  logic              reset = 1'b0;
  logic [NB-1:0]     bank_req = '0;
  logic [NB-1:0]     bank_grant;
  logic [NB-1:0]     bank_valid = '0;
  logic [NB-1:0]     bank_sos = '0;
  logic [NB-1:0]     bank_eos = '0;
  logic [NB*16-1:0]  bank_data = '0;
  logic [NB*NW-1:0]  bank_node_id = '0;
  logic              sram_wen;
  logic [AW-1:0]     sram_addr;
  logic [15:0]       sram_wdata;
  logic              busy;
  logic              stream_err;

  output_sram_write_arbiter #(.NUM_BANKS(NB), .MAX_FV_NUM(FV), .NODE_ID_W(NW)) dut (
    .clk(clk), .reset(reset), .bank_req(bank_req), .bank_grant(bank_grant),
    .bank_valid(bank_valid), .bank_sos(bank_sos), .bank_eos(bank_eos),
    .bank_data(bank_data), .bank_node_id(bank_node_id), .sram_wen(sram_wen),
    .sram_addr(sram_addr), .sram_wdata(sram_wdata), .busy(busy), .stream_err(stream_err)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [AW-1:0] addr;
    logic [15:0]   data;
    logic [31:0]   cyc;
  } wr_t;

  wr_t           wr_q[$];
  wr_t           exp_q[$];
  int            grant_log[$];
  int            grant_start[$];
  int            grant_cycles[NB];
  logic [NB-1:0] prev_grant = '0;
  int            cyc = 0;
  int            checks = 0;
  int            errors = 0;
  logic          exp_err = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  // Monitor: log every write and the start of every grant, and check grant is one-hot or zero
  always @(negedge clk) begin
    if (reset) begin
      if (sram_wen) wr_q.push_back({sram_addr, sram_wdata, 32'(cyc)});
      checks++;
      if ($countones(bank_grant) > 1) begin
        errors++;
        $display("[TB] FAIL grant_onehot got %b", bank_grant);
      end
      for (int b = 0; b < NB; b++) begin
        if (bank_grant[b]) begin
          grant_cycles[b]++;
          if (prev_grant == '0) begin
            grant_log.push_back(b);
            grant_start.push_back(cyc);
          end
        end
      end
    end
    prev_grant = bank_grant;
  end

  initial begin
    #400000;
    $display("[TB] FAIL watchdog expired at cycle %0d", cyc);
    $fatal(1, "[TB] watchdog");
  end

  task automatic clear_logs();
    wr_q.delete();
    exp_q.delete();
    grant_log.delete();
    grant_start.delete();
    for (int b = 0; b < NB; b++) grant_cycles[b] = 0;
    exp_err = 1'b0;
  endtask

  task automatic do_reset();
    reset = 1'b0;
    bank_req = '0; bank_valid = '0; bank_sos = '0; bank_eos = '0;
    bank_data = '0; bank_node_id = '0;
    repeat (2) @(negedge clk);
    reset = 1'b1;
    clear_logs();
  endtask

  function automatic logic [127:0] rand_beats();
    return {$urandom(), $urandom(), $urandom(), $urandom()};
  endfunction

  // Bank model: request, wait for grant, optionally stall, then offer nbeats beats
  task automatic run_stream(input int b, input int node, input int nbeats, input int has_eos,
                            input int pre_delay, input int max_gap, input int sos_again,
                            input logic [127:0] dat);
    int waited;
    int gap;
    @(negedge clk);
    bank_req[b] = 1'b1;
    bank_node_id[b*NW +: NW] = NW'(node);
    waited = 0;
    while (!bank_grant[b] && waited < 100) begin
      @(negedge clk);
      waited++;
    end
    checks++;
    if (!bank_grant[b]) begin
      errors++;
      $display("[TB] FAIL grant_timeout bank %0d got no grant want grant", b);
      bank_req[b] = 1'b0;
      return;
    end
    repeat (pre_delay) @(negedge clk);
    for (int j = 0; j < nbeats; j++) begin
      bank_valid[b] = 1'b1;
      bank_sos[b]   = (j == 0 || j == sos_again);
      bank_eos[b]   = (has_eos != 0 && j == nbeats - 1);
      bank_data[b*16 +: 16] = dat[j*16 +: 16];
      if (j == 0) bank_req[b] = 1'b0;
      if (j < WPN) exp_q.push_back({AW'(node * WPN + j), dat[j*16 +: 16], 32'(cyc + 1)});
      if (j == sos_again) exp_err = 1'b1;
      if (j == WPN - 1 && !bank_eos[b]) exp_err = 1'b1;
      @(negedge clk);
      if (j < nbeats - 1 && max_gap > 0) begin
        gap = $urandom_range(0, max_gap);
        if (gap > 0) begin
          bank_valid[b] = 1'b0;
          repeat (gap) @(negedge clk);
        end
      end
    end
    bank_valid[b] = 1'b0;
    bank_sos[b]   = 1'b0;
    bank_eos[b]   = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b0;
    @(negedge clk);
    checks++; if (sram_wen !== 1'b0) begin errors++; $display("[TB] FAIL reset_wen got %b want 0", sram_wen); end
    checks++; if (sram_addr !== '0) begin errors++; $display("[TB] FAIL reset_addr got %0d want 0", sram_addr); end
    checks++; if (sram_wdata !== '0) begin errors++; $display("[TB] FAIL reset_wdata got %h want 0", sram_wdata); end
    checks++; if (bank_grant !== '0) begin errors++; $display("[TB] FAIL reset_grant got %b want 0", bank_grant); end
    checks++; if (busy !== 1'b0) begin errors++; $display("[TB] FAIL reset_busy got %b want 0", busy); end
    checks++; if (stream_err !== 1'b0) begin errors++; $display("[TB] FAIL reset_err got %b want 0", stream_err); end
  endtask

  task automatic test_single_stream();
    do_reset();
    run_stream(1, 5, 4, 1, 0, 0, -1, 128'h0708_0506_0304_0102);
    repeat (2) @(negedge clk);
    checks++;
    if (wr_q.size() != exp_q.size()) begin
      errors++; $display("[TB] FAIL single_count got %0d want %0d", wr_q.size(), exp_q.size());
    end else foreach (exp_q[i]) begin
      checks++;
      if (wr_q[i] !== exp_q[i]) begin
        errors++;
        $display("[TB] FAIL single_write%0d got addr %0d data %h cyc %0d want addr %0d data %h cyc %0d",
                 i, wr_q[i].addr, wr_q[i].data, wr_q[i].cyc, exp_q[i].addr, exp_q[i].data, exp_q[i].cyc);
      end
    end
    checks++; if (wr_q.size() > 0 && wr_q[0].addr !== AW'(20)) begin errors++; $display("[TB] FAIL single_first_addr got %0d want 20", wr_q[0].addr); end
    checks++; if (grant_cycles[1] != 1) begin errors++; $display("[TB] FAIL single_grant_cycles got %0d want 1", grant_cycles[1]); end
    checks++; if (busy !== 1'b0) begin errors++; $display("[TB] FAIL single_busy got %b want 0", busy); end
    checks++; if (stream_err !== exp_err) begin errors++; $display("[TB] FAIL single_err got %b want %b", stream_err, exp_err); end
  endtask

  task automatic test_single_beat();
    do_reset();
    run_stream(0, 3, 1, 1, 0, 0, -1, 128'hAABB);
    checks++; if (busy !== 1'b0) begin errors++; $display("[TB] FAIL beat_busy got %b want 0", busy); end
    repeat (2) @(negedge clk);
    checks++;
    if (wr_q.size() != 1 || exp_q.size() != 1) begin
      errors++; $display("[TB] FAIL beat_count got %0d want 1", wr_q.size());
    end else if (wr_q[0] !== exp_q[0] || wr_q[0].addr !== AW'(12)) begin
      errors++; $display("[TB] FAIL beat_write got addr %0d data %h want addr %0d data %h",
                         wr_q[0].addr, wr_q[0].data, exp_q[0].addr, exp_q[0].data);
    end
    // rr_ptr is now 1, so bank 1 beats bank 0 when both ask together
    grant_log.delete();
    fork
      run_stream(0, 1, 1, 1, 0, 0, -1, rand_beats());
      run_stream(1, 2, 1, 1, 0, 0, -1, rand_beats());
    join
    checks++;
    if (grant_log.size() != 2 || grant_log[0] != 1 || grant_log[1] != 0) begin
      errors++; $display("[TB] FAIL beat_rr_order got %p want '{1, 0}", grant_log);
    end
  endtask

  task automatic test_round_robin();
    int exp_order[4] = '{0, 2, 3, 0};
    do_reset();
    fork
      begin
        run_stream(0, 10, 2, 1, 0, 0, -1, rand_beats());
        run_stream(0, 11, 2, 1, 0, 0, -1, rand_beats());
      end
      run_stream(2, 12, 2, 1, 0, 0, -1, rand_beats());
      run_stream(3, 13, 2, 1, 0, 0, -1, rand_beats());
    join
    repeat (2) @(negedge clk);
    checks++;
    if (grant_log.size() != 4) begin
      errors++; $display("[TB] FAIL rr_count got %0d want 4", grant_log.size());
    end else begin
      for (int k = 0; k < 4; k++) begin
        checks++;
        if (grant_log[k] != exp_order[k]) begin errors++; $display("[TB] FAIL rr_order%0d got %0d want %0d", k, grant_log[k], exp_order[k]); end
      end
      // Two-beat streams: eos beat one cycle after grant, then IDLE, then the next grant
      for (int k = 0; k < 3; k++) begin
        checks++;
        if (grant_start[k+1] - grant_start[k] != 3) begin
          errors++; $display("[TB] FAIL rr_gap%0d got %0d want 3", k, grant_start[k+1] - grant_start[k]);
        end
      end
    end
    checks++;
    if (wr_q.size() != exp_q.size()) begin
      errors++; $display("[TB] FAIL rr_write_count got %0d want %0d", wr_q.size(), exp_q.size());
    end else foreach (exp_q[i]) begin
      checks++;
      if (wr_q[i] !== exp_q[i]) begin errors++; $display("[TB] FAIL rr_write%0d got addr %0d data %h want addr %0d data %h", i, wr_q[i].addr, wr_q[i].data, exp_q[i].addr, exp_q[i].data); end
    end
  endtask

  task automatic test_grant_hold();
    do_reset();
    fork
      run_stream(2, 20, 3, 1, 3, 0, -1, rand_beats());
      begin
        repeat (2) @(negedge clk);
        run_stream(1, 21, 2, 1, 0, 0, -1, rand_beats());
      end
    join
    repeat (2) @(negedge clk);
    checks++; if (grant_cycles[2] != 4) begin errors++; $display("[TB] FAIL hold_grant_cycles got %0d want 4", grant_cycles[2]); end
    checks++;
    if (grant_log.size() != 2 || grant_log[0] != 2 || grant_log[1] != 1) begin
      errors++; $display("[TB] FAIL hold_order got %p want '{2, 1}", grant_log);
    end
    checks++;
    if (wr_q.size() != exp_q.size()) begin
      errors++; $display("[TB] FAIL hold_write_count got %0d want %0d", wr_q.size(), exp_q.size());
    end else foreach (exp_q[i]) begin
      checks++;
      if (wr_q[i] !== exp_q[i]) begin errors++; $display("[TB] FAIL hold_write%0d got addr %0d cyc %0d want addr %0d cyc %0d", i, wr_q[i].addr, wr_q[i].cyc, exp_q[i].addr, exp_q[i].cyc); end
    end
  endtask

  task automatic test_overflow();
    do_reset();
    run_stream(1, 9, 5, 0, 0, 1, -1, rand_beats());
    repeat (2) @(negedge clk);
    checks++;
    if (wr_q.size() != exp_q.size()) begin
      errors++; $display("[TB] FAIL ovf_write_count got %0d want %0d", wr_q.size(), exp_q.size());
    end else foreach (exp_q[i]) begin
      checks++;
      if (wr_q[i] !== exp_q[i]) begin errors++; $display("[TB] FAIL ovf_write%0d got addr %0d data %h want addr %0d data %h", i, wr_q[i].addr, wr_q[i].data, exp_q[i].addr, exp_q[i].data); end
    end
    checks++; if (stream_err !== exp_err) begin errors++; $display("[TB] FAIL ovf_err got %b want %b", stream_err, exp_err); end
    checks++; if (busy !== 1'b0) begin errors++; $display("[TB] FAIL ovf_busy got %b want 0", busy); end
    repeat (5) @(negedge clk);
    checks++; if (stream_err !== 1'b1) begin errors++; $display("[TB] FAIL ovf_err_sticky got %b want 1", stream_err); end
  endtask

  task automatic test_early_sos();
    do_reset();
    run_stream(3, 7, 3, 1, 0, 0, 1, rand_beats());
    repeat (2) @(negedge clk);
    checks++;
    if (wr_q.size() != exp_q.size()) begin
      errors++; $display("[TB] FAIL esos_write_count got %0d want %0d", wr_q.size(), exp_q.size());
    end else foreach (exp_q[i]) begin
      checks++;
      if (wr_q[i] !== exp_q[i]) begin errors++; $display("[TB] FAIL esos_write%0d got addr %0d data %h want addr %0d data %h", i, wr_q[i].addr, wr_q[i].data, exp_q[i].addr, exp_q[i].data); end
    end
    checks++; if (stream_err !== exp_err) begin errors++; $display("[TB] FAIL esos_err got %b want %b", stream_err, exp_err); end
  endtask

  task automatic test_reset_mid_stream();
    int waited;
    do_reset();
    run_stream(0, 1, 2, 1, 0, 0, -1, rand_beats());
    @(negedge clk);
    bank_req[1] = 1'b1;
    bank_node_id[NW +: NW] = NW'(2);
    waited = 0;
    while (!bank_grant[1] && waited < 100) begin
      @(negedge clk);
      waited++;
    end
    checks++; if (!bank_grant[1]) begin errors++; $display("[TB] FAIL rst_grant got %b want 0010", bank_grant); end
    bank_valid[1] = 1'b1; bank_sos[1] = 1'b1; bank_req[1] = 1'b0; bank_data[16 +: 16] = 16'h1111;
    @(negedge clk);
    bank_sos[1] = 1'b0; bank_data[16 +: 16] = 16'h2222;
    @(negedge clk);
    bank_data[16 +: 16] = 16'h3333;
    checks++; if (sram_wen !== 1'b1) begin errors++; $display("[TB] FAIL rst_pending_wen got %b want 1", sram_wen); end
    #2 reset = 1'b0;
    #1;
    checks++; if (sram_wen !== 1'b0) begin errors++; $display("[TB] FAIL rst_wen_drop got %b want 0", sram_wen); end
    checks++; if (bank_grant !== '0) begin errors++; $display("[TB] FAIL rst_grant_drop got %b want 0", bank_grant); end
    checks++; if (busy !== 1'b0) begin errors++; $display("[TB] FAIL rst_busy got %b want 0", busy); end
    bank_valid = '0; bank_sos = '0; bank_eos = '0;
    @(negedge clk);
    reset = 1'b1;
    clear_logs();
    repeat (3) @(negedge clk);
    checks++; if (wr_q.size() != 0) begin errors++; $display("[TB] FAIL rst_stale_write got %0d writes want 0", wr_q.size()); end
    // rr_ptr back at 0: bank 0 wins over bank 1
    fork
      run_stream(1, 4, 1, 1, 0, 0, -1, rand_beats());
      run_stream(0, 5, 1, 1, 0, 0, -1, rand_beats());
    join
    checks++;
    if (grant_log.size() < 1 || grant_log[0] != 0) begin
      errors++; $display("[TB] FAIL rst_rr_ptr got %p want first grant 0", grant_log);
    end
  endtask

  task automatic test_random();
    int exp_banks[$];
    int b, nb, n;
    bit done;
    do_reset();
    for (int it = 0; it < 12; it++) begin
      b  = $urandom_range(0, NB - 1);
      nb = (b + 1) % NB;
      n  = $urandom_range(1, WPN);
      exp_banks.push_back(b);
      done = 1'b0;
      fork
        begin
          run_stream(b, $urandom_range(0, 63), n, 1, $urandom_range(0, 2), 2, -1, rand_beats());
          done = 1'b1;
        end
        begin
          while (!done) begin
            bank_valid[nb] = 1'($urandom);
            bank_sos[nb]   = 1'($urandom);
            bank_eos[nb]   = 1'($urandom);
            bank_data[nb*16 +: 16] = 16'($urandom);
            bank_node_id[nb*NW +: NW] = NW'($urandom);
            @(negedge clk);
          end
          bank_valid[nb] = 1'b0; bank_sos[nb] = 1'b0; bank_eos[nb] = 1'b0;
        end
      join
    end
    repeat (2) @(negedge clk);
    checks++;
    if (grant_log != exp_banks) begin errors++; $display("[TB] FAIL rand_order got %p want %p", grant_log, exp_banks); end
    checks++;
    if (wr_q.size() != exp_q.size()) begin
      errors++; $display("[TB] FAIL rand_write_count got %0d want %0d", wr_q.size(), exp_q.size());
    end else foreach (exp_q[i]) begin
      checks++;
      if (wr_q[i] !== exp_q[i]) begin
        errors++;
        $display("[TB] FAIL rand_write%0d got addr %0d data %h cyc %0d want addr %0d data %h cyc %0d",
                 i, wr_q[i].addr, wr_q[i].data, wr_q[i].cyc, exp_q[i].addr, exp_q[i].data, exp_q[i].cyc);
      end
    end
    checks++; if (stream_err !== exp_err) begin errors++; $display("[TB] FAIL rand_err got %b want %b", stream_err, exp_err); end
  endtask

  initial begin
    test_reset();
    test_single_stream();
    test_single_beat();
    test_round_robin();
    test_grant_hold();
    test_overflow();
    test_early_sos();
    test_reset_mid_stream();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
